// File: rtl/pts_tx_pkg.sv
// Shared types and constants for the parallel-to-serial transmit controller.
package pts_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pts_tx_state_t;

    // Width of the downstream shift register.
    localparam int BYTE_W = 8;

endpackage

// File: rtl/pts_bit_timer.sv
// Wrap counter that measures how long each bit is held on serial_out.
// terminal is high in the last clock of every bit period.
module pts_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    // Count 0..CLKS_PER_BIT-1 while enabled, restart on clear or on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + W'(1);
        end
    end

    // With CLKS_PER_BIT == 1 the counter is stuck at 0, so terminal is always high.
    assign terminal = (count == LAST);

endmodule

// File: rtl/pts_tx_ctrl.sv
// Transmit controller feeding an MSB-first parallel-to-serial shift register.
// Buffers one byte behind a valid/ready handshake and sequences load/shift
// pulses so every bit is held for CLKS_PER_BIT clocks, with gapless reloads.
module pts_tx_ctrl
    import pts_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = BYTE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                load_enable,
    output logic                shift_enable,
    output logic                tx_active,
    output logic                byte_done
);

    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    pts_tx_state_t       state;
    pts_tx_state_t       state_next;
    logic                pending_valid;
    logic [NUM_BITS-1:0] pending_data;
    logic [CNT_W-1:0]    bit_cnt;
    logic                shifting;
    logic                bit_end;
    logic                last_bit;
    logic                word_end;
    logic                load;

    assign shifting = (state == SHIFT);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign word_end = shifting && bit_end && last_bit;

    // A pending byte loads from IDLE at once, or in the terminal cycle of the
    // current byte's last bit so the next byte abuts with no gap.
    assign load = pending_valid && (!shifting || word_end);

    pts_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (load),
        .enable   (shifting),
        .terminal (bit_end)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic: enter SHIFT on a load, leave it when the word ends unreloaded.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (load) begin
            state_next = SHIFT;
        end else if (word_end) begin
            state_next = IDLE;
        end
    end

    // Output logic: strobes for the shift register and status flags.
    always_comb begin
        load_enable  = load;
        shift_enable = shifting && bit_end && !last_bit;
        byte_done    = word_end;
        tx_active    = shifting;
    end

    // Ready comes straight from a flop, so there is no path from tx_valid.
    assign tx_ready     = !pending_valid;
    assign parallel_out = pending_data;

    // One-entry buffer: filled on handshake, emptied when its byte is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_valid <= 1'b0;
            // NOTE: the data register is reset too, so parallel_out reads 0 out of reset.
            pending_data  <= '0;
        end else if (load) begin
            pending_valid <= 1'b0;
        end else if (tx_valid && !pending_valid) begin
            pending_valid <= 1'b1;
            pending_data  <= tx_data;
        end
    end

    // Bit index within the word: restarts on load, steps on every shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= '0;
        end else if (shift_enable) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end else if (word_end) begin
            bit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Bench for pts_tx_ctrl: two instances (CLKS_PER_BIT=4 and 1), each driving a
// behavioural MSB-first shift register, with a per-instance scoreboard.
module tb_pts_tx_ctrl;

    localparam int NB = 8;
    localparam int C0 = 4;
    localparam int C1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txd0 = 8'h00;
    logic [7:0] txd1 = 8'h00;
    logic [1:0] txv = 2'b00;
    logic [1:0] tr, le, se, ta, bd, so;
    logic [7:0] po0, po1;
    logic [7:0] sr0, sr1;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pts_tx_ctrl #(.CLKS_PER_BIT(C0), .NUM_BITS(NB)) dut4 (
        .clk(clk), .rst(rst), .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(tr[0]),
        .parallel_out(po0), .load_enable(le[0]), .shift_enable(se[0]),
        .tx_active(ta[0]), .byte_done(bd[0])
    );

    pts_tx_ctrl #(.CLKS_PER_BIT(C1), .NUM_BITS(NB)) dut1 (
        .clk(clk), .rst(rst), .tx_data(txd1), .tx_valid(txv[1]), .tx_ready(tr[1]),
        .parallel_out(po1), .load_enable(le[1]), .shift_enable(se[1]),
        .tx_active(ta[1]), .byte_done(bd[1])
    );

    // Downstream shift registers, sharing the controller reset.
    always @(posedge clk or posedge rst) begin
        if (rst)        sr0 <= 8'h00;
        else if (le[0]) sr0 <= po0;
        else if (se[0]) sr0 <= {sr0[6:0], 1'b0};
    end

    always @(posedge clk or posedge rst) begin
        if (rst)        sr1 <= 8'h00;
        else if (le[1]) sr1 <= po1;
        else if (se[1]) sr1 <= {sr1[6:0], 1'b0};
    end

    assign so[0] = sr0[7];
    assign so[1] = sr1[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected serial bit patterns, one queue per instance.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         mon_idx[2] = '{0, 0};
    bit         mon_act[2] = '{1'b0, 1'b0};
    logic [7:0] mon_cur[2] = '{8'h00, 8'h00};

    function automatic int q_size(input int k);
        if (k == 0) return q0.size();
        return q1.size();
    endfunction

    task automatic q_push(input int k, input logic [7:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic q_pop(input int k, output logic [7:0] v);
        if (k == 0) v = q0.pop_front();
        else        v = q1.pop_front();
    endtask

    task automatic q_clear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    // Per-cycle model of one instance: bit values, strobe timing, gapless reload.
    task automatic mon(input int k, input int c);
        int         tot;
        logic [7:0] cur;
        int         bi;
        tot = NB * c;
        if (rst) begin
            mon_act[k] = 1'b0;
            mon_idx[k] = 0;
            q_clear(k);
        end else begin
            check($sformatf("mutex_load_shift[%0d]", k), 32'(se[k] && le[k]), 0);
            check($sformatf("tx_active[%0d]", k), 32'(ta[k]), 32'(mon_act[k]));
            if (mon_act[k]) begin
                cur = mon_cur[k];
                bi  = 7 - mon_idx[k] / c;
                check($sformatf("serial_out[%0d] idx %0d", k, mon_idx[k]), 32'(so[k]), 32'(cur[bi]));
                check($sformatf("byte_done[%0d] idx %0d", k, mon_idx[k]), 32'(bd[k]),
                      32'(mon_idx[k] == tot - 1));
                check($sformatf("shift_enable[%0d] idx %0d", k, mon_idx[k]), 32'(se[k]),
                      32'((mon_idx[k] % c == c - 1) && (mon_idx[k] < (NB - 1) * c)));
                if (mon_idx[k] == tot - 1 && q_size(k) != 0)
                    check($sformatf("gapless_reload[%0d]", k), 32'(le[k]), 1);
                mon_idx[k]++;
                if (mon_idx[k] == tot) mon_act[k] = 1'b0;
            end else begin
                check($sformatf("idle_byte_done[%0d]", k), 32'(bd[k]), 0);
                check($sformatf("idle_shift[%0d]", k), 32'(se[k]), 0);
                if (q_size(k) != 0)
                    check($sformatf("load_from_idle[%0d]", k), 32'(le[k]), 1);
            end
            check($sformatf("load_while_busy[%0d]", k), 32'(le[k] && mon_act[k]), 0);
            check($sformatf("load_without_byte[%0d]", k), 32'(le[k] && q_size(k) == 0), 0);
            if (le[k] && q_size(k) != 0) begin
                q_pop(k, cur);
                mon_cur[k] = cur;
                mon_idx[k] = 0;
                mon_act[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, C0);
        mon(1, C1);
    end

    // Offer one byte, holding tx_valid until accepted; exp is its serial pattern.
    task automatic send(input int k, input logic [7:0] d, input logic [7:0] exp, output int waited);
        @(negedge clk);
        if (k == 0) txd0 = d;
        else        txd1 = d;
        txv[k] = 1'b1;
        waited = 0;
        while (!tr[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("send_accept[%0d] %0h", k, d), 32'(tr[k]), 1);
        if (tr[k]) begin
            @(posedge clk);
            q_push(k, exp);
            #1;
        end
        txv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((ta[k] || mon_act[k] || q_size(k) != 0 || !tr[k]) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("idle_timeout[%0d]", k), 32'(n >= 400), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;
        int         exp_done;   // negedges from handshake+1 to byte_done
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         w;
        int         n;
        int         contig;
        logic [15:0] stream;

        // Load edge is one cycle after the handshake; byte_done 32 cycles after it.
        vecs[0] = '{8'hA5, 8'b1010_0101, 33};
        vecs[1] = '{8'h00, 8'b0000_0000, 33};
        vecs[2] = '{8'hFF, 8'b1111_1111, 33};
        vecs[3] = '{8'h3C, 8'b0011_1100, 33};

        // Reset state, then idle after release.
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tr[0]), 1);
        check("rst_load", 32'(le[0]), 0);
        check("rst_active", 32'(ta[0]), 0);
        check("rst_parallel_out", 32'(po0), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_tx_ready", 32'(tr[0]), 1);
        check("idle_load", 32'(le[0]), 0);
        check("idle_shift_en", 32'(se[0]), 0);
        check("idle_active", 32'(ta[0]), 0);
        check("idle_done", 32'(bd[0]), 0);

        // Single bytes from the vector table.
        for (int i = 0; i < 4; i++) begin
            send(0, vecs[i].data, vecs[i].exp_bits, w);
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                n++;
                if (bd[0]) break;
            end
            check($sformatf("done_latency %0h", vecs[i].data), 32'(n), 32'(vecs[i].exp_done));
            @(negedge clk);
            check($sformatf("after_done_active %0h", vecs[i].data), 32'(ta[0]), 0);
            check($sformatf("after_done_ready %0h", vecs[i].data), 32'(tr[0]), 1);
            wait_idle(0);
        end

        // Back-to-back 0xA5, 0x3C: 64 contiguous active cycles.
        fork
            begin
                n = 0;
                while (!le[0] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                contig = 0;
                @(negedge clk);
                while (ta[0] && contig < 200) begin
                    contig++;
                    @(negedge clk);
                end
                check("b2b_contiguous_cycles", 32'(contig), 64);
            end
            begin
                send(0, 8'hA5, 8'b1010_0101, w);
                send(0, 8'h3C, 8'b0011_1100, w);
                check("b2b_second_accept_wait", 32'(w), 1);
            end
        join
        wait_idle(0);

        // Backpressure: third byte held until the second one loads.
        send(0, 8'hA5, 8'b1010_0101, w);
        send(0, 8'h3C, 8'b0011_1100, w);
        send(0, 8'hFF, 8'b1111_1111, w);
        check("bp_ready_low_cycles", 32'(w), 31);
        wait_idle(0);
        check("bp_queue_empty", 32'(q_size(0)), 0);

        // CLKS_PER_BIT = 1: 0x80 then 0x01 on consecutive cycles.
        fork
            begin
                n = 0;
                while (!le[1] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                stream = 16'h0000;
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    stream = {stream[14:0], so[1]};
                end
                check("cpb1_stream", 32'(stream), 32'h8001);
            end
            begin
                send(1, 8'h80, 8'b1000_0000, w);
                send(1, 8'h01, 8'b0000_0001, w);
            end
        join
        wait_idle(1);

        // Reset during bit 4 of 0xC3 with 0x5A pending.
        send(0, 8'hC3, 8'b1100_0011, w);
        send(0, 8'h5A, 8'b0101_1010, w);
        n = 0;
        while (!(mon_act[0] && mon_idx[0] == 17) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_byte_reached", 32'(n < 100), 1);
        check("mid_byte_pending", 32'(tr[0]), 0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(tr[0]), 1);
        check("async_rst_active", 32'(ta[0]), 0);
        check("async_rst_load", 32'(le[0]), 0);
        check("async_rst_shift", 32'(se[0]), 0);
        check("async_rst_done", 32'(bd[0]), 0);
        check("async_rst_par_out", 32'(po0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_load", 32'(le[0]), 0);
            check("post_rst_ready", 32'(tr[0]), 1);
        end
        send(0, 8'h81, 8'b1000_0001, w);
        check("post_rst_accept_wait", 32'(w), 0);
        wait_idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pts_tx_ctrl.md
Name: pts_tx_ctrl

Overview:
- Transmit controller sitting directly upstream of the 8-bit MSB-first parallel-to-serial shift register (pts_sr_8_msb).
- Accepts bytes over a valid/ready handshake and buffers one byte.
- Drives the shift register's parallel_in, load_enable and shift_enable so each bit is held on serial_out for exactly CLKS_PER_BIT clocks.
- Back-to-back bytes are sent with no idle gap.

Parameters:
- CLKS_PER_BIT, default 10, clocks each bit is held on serial_out; legal range >= 1.
- NUM_BITS, default 8, bits per word; must match the downstream shift register width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  NUM_BITS  byte to transmit; sampled on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  pending buffer empty; byte accepted on the edge where tx_valid && tx_ready.
- parallel_out  output  NUM_BITS  to SR parallel_in; always equals the pending buffer contents.
- load_enable  output  1  one-cycle pulse; SR loads parallel_out on the next edge.
- shift_enable  output  1  one-cycle pulse; SR shifts one bit on the next edge.
- tx_active  output  1  high while a byte is being serialised (state SHIFT).
- byte_done  output  1  one-cycle pulse in the final cycle of the last bit of each byte.

Interface rules:
- One clock; reset is asynchronous and active-high.
- Clock port is clk; reset port is rst.

Behaviour:
- Registers:
  - pending_valid and pending_data, a 1-entry buffer.
  - state in {IDLE, SHIFT}.
  - bit_timer, counting 0..CLKS_PER_BIT-1; width max(1, $clog2(CLKS_PER_BIT)).
  - bit_cnt, counting 0..NUM_BITS-1.
- Reset (asynchronous, any time, including mid-byte):
  - state=IDLE, pending_valid=0, pending_data=0, bit_timer=0, bit_cnt=0.
  - Outputs: load_enable=0, shift_enable=0, tx_active=0, byte_done=0, parallel_out=0.
  - tx_ready=1, but no byte is captured while rst is high.
  - A partially sent byte is discarded; the downstream SR is reset on the same net.
- Handshake:
  - tx_ready = !pending_valid, derived from a register only; no combinational path from tx_valid.
  - On an edge with tx_valid && tx_ready: pending_data <= tx_data, pending_valid <= 1.
- Load condition (combinational): L = pending_valid && (state==IDLE || (state==SHIFT && T && bit_cnt==NUM_BITS-1)), where T = (bit_timer==CLKS_PER_BIT-1).
  - load_enable = L.
  - On the edge ending a cycle with L: pending_valid <= 0, state <= SHIFT, bit_timer <= 0, bit_cnt <= 0.
- SHIFT state:
  - bit_timer increments each cycle and wraps to 0 at T.
  - shift_enable = T && bit_cnt < NUM_BITS-1; on that edge bit_cnt increments.
  - At T && bit_cnt==NUM_BITS-1: byte_done=1. Next state is SHIFT if L (reload, gapless), else IDLE.
  - shift_enable and load_enable are never high in the same cycle.
- Latency and timing:
  - Handshake edge E0 → load_enable high in cycle E0..E1 → MSB on serial_out from E1.
  - Byte occupies exactly NUM_BITS*CLKS_PER_BIT cycles.
  - Consecutive bytes abut with zero gap when the next byte is pending before the last bit's terminal cycle.
- Simultaneous events:
  - A handshake cannot coincide with L's clearing of pending_valid, because tx_ready is 0 while pending_valid is 1.
  - A new byte is accepted from the cycle after a load onwards.
- CLKS_PER_BIT=1: T is always true; shift_enable is high on 7 consecutive cycles, then byte_done (with load_enable if pending).

Decomposition:
- Package pts_tx_pkg contains:
  - typedef enum logic {IDLE, SHIFT} pts_tx_state_t;
  - localparam BYTE_W = 8.
- One sub-module, pts_bit_timer: parameterised wrap counter.
  - Inputs: clear, enable.
  - Output: terminal T.
  - Uses the same asynchronous active-high reset.

Test Plan (CLKS_PER_BIT=4 unless stated; DUT output wired to pts_sr_8_msb):
1. Release reset, idle 10 cycles → tx_ready=1; load_enable, shift_enable, tx_active and byte_done all 0.
2. Single byte 0xA5 at E0:
   - load_enable 1 cycle.
   - serial_out = 1,0,1,0,0,1,0,1, each bit 4 cycles.
   - 7 shift_enable pulses 4 apart.
   - byte_done at cycle 32 after the load edge; then IDLE and tx_active=0.
3. 0xA5 then 0x3C offered back-to-back:
   - Second byte accepted the cycle after the first load.
   - load_enable coincides with the first byte_done.
   - 64 contiguous cycles of serial data with no gap.
4. Backpressure: hold tx_valid with a third byte 0xFF while pending is full → tx_ready=0 until the second byte loads; the third byte is then accepted exactly once.
5. CLKS_PER_BIT=1, stream 0x80 and 0x01 → serial_out = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 on consecutive cycles.
6. Assert rst during bit 4 of 0xC3 with a byte pending → asynchronously IDLE, pending cleared, tx_ready=1; after release no load_enable occurs until a new handshake.
